// File: rtl/branch_pkg.sv
// branch_pkg: shared types and constants for the branch resolution tracker
package branch_pkg;
  localparam int BR_PC_W = 32;
  typedef struct packed {
    logic [BR_PC_W-1:0] pc;
    logic               pred;
  } br_entry_t;
endpackage

// File: rtl/branch_pred_queue.sv
// branch_pred_queue: in-order circular buffer of in-flight branch predictions
import branch_pkg::*;
module branch_pred_queue #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      enq,
  input  br_entry_t enq_data,
  input  logic      deq,
  input  logic      flush,
  output br_entry_t deq_data,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  br_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  assign deq_data = r_mem[r_head];
  assign full     = r_count == (AW+1)'(DEPTH);
  assign empty    = r_count == '0;
  // pointers and occupancy; a flush squashes everything in flight and any same-cycle push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      r_tail  <= enq ? r_tail + AW'(1) : r_tail;
      r_head  <= deq ? r_head + AW'(1) : r_head;
      r_count <= r_count + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end
  // storage write at tail, not reset
  always_ff @(posedge clk) begin
    if (enq && !flush) r_mem[r_tail] <= enq_data;
  end
endmodule

// File: rtl/branch_resolve_tracker.sv
// branch_resolve_tracker: matches resolved outcomes to queued predictions and drives predictor training
import branch_pkg::*;
module branch_resolve_tracker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pred_val,
  output logic                 pred_rdy,
  input  logic [BR_PC_W-1:0]   pred_pc,
  input  logic                 pred_taken,
  input  logic                 resolve_val,
  output logic                 resolve_rdy,
  input  logic                 resolve_taken,
  output logic                 update_en,
  output logic                 update_val,
  output logic [BR_PC_W-1:0]   update_pc,
  output logic                 mispredict,
  output logic [CNT_W-1:0]     num_branches,
  output logic [CNT_W-1:0]     num_mispred
);
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_res;
  logic               w_mis;
  br_entry_t          w_head;
  br_entry_t          w_new;
  logic               r_en;
  logic               r_val;
  logic [BR_PC_W-1:0] r_pc;
  logic               r_mis;
  logic [CNT_W-1:0]   r_nb;
  logic [CNT_W-1:0]   r_nm;
  assign pred_rdy     = !w_full && !reset;
  assign resolve_rdy  = !w_empty && !reset;
  assign w_push       = pred_val && pred_rdy;
  assign w_res        = resolve_val && resolve_rdy;
  assign w_mis        = w_res && (resolve_taken != w_head.pred);
  assign w_new        = '{pc: pred_pc, pred: pred_taken};
  assign update_en    = r_en;
  assign update_val   = r_val;
  assign update_pc    = r_pc;
  assign mispredict   = r_mis;
  assign num_branches = r_nb;
  assign num_mispred  = r_nm;
  branch_pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (reset),
    .enq      (w_push),
    .enq_data (w_new),
    .deq      (w_res),
    .flush    (w_mis),
    .deq_data (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );
  // registered training update, misprediction pulse and saturating statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en  <= 1'b0;
      r_val <= 1'b0;
      r_pc  <= '0;
      r_mis <= 1'b0;
      r_nb  <= '0;
      r_nm  <= '0;
    end else begin
      r_en  <= w_res;
      r_mis <= w_mis;
      r_val <= w_res ? resolve_taken : r_val;
      r_pc  <= w_res ? w_head.pc : r_pc;
      r_nb  <= (w_res && !(&r_nb)) ? r_nb + CNT_W'(1) : r_nb;
      r_nm  <= (w_mis && !(&r_nm)) ? r_nm + CNT_W'(1) : r_nm;
    end
  end
endmodule

// File: doc/branch_resolve_tracker.md
Name: branch_resolve_tracker

Overview:
- Resolution-side partner of the branch predictors. Consumes predictions at fetch and outcomes at execute, and produces the predictor's training interface (update_en / update_val).
- Holds the in-flight {PC, prediction} pairs in an in-order queue.
- When a branch resolves, it compares the actual outcome with the stored prediction, emits one registered update per branch and flags mispredictions.
- Keeps saturating branch and misprediction counters for evaluating predictors.

Parameters:
- DEPTH, 4, number of in-flight branch entries (power of 2, at least 2)
- CNT_W, 16, width of the statistics counters

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- pred_val  input  1  fetch presents a predicted branch
- pred_rdy  output  1  queue can accept an entry
- pred_pc  input  32  PC of the predicted branch
- pred_taken  input  1  prediction bit issued by the predictor
- resolve_val  input  1  execute resolves the oldest in-flight branch
- resolve_rdy  output  1  at least one entry is in flight
- resolve_taken  input  1  actual branch outcome
- update_en  output  1  predictor training strobe
- update_val  output  1  actual outcome to train with
- update_pc  output  32  PC of the trained branch
- mispredict  output  1  one-cycle pulse: prediction was wrong
- num_branches  output  CNT_W  resolved-branch count
- num_mispred  output  CNT_W  misprediction count

Behaviour:
- Clock and reset:
  - One clock: clk.
  - reset is asynchronous and active-high; asserting it at any time, including mid-operation, immediately clears state.
  - Cleared state: head/tail pointers = 0, count = 0, update_en = 0, update_val = 0, update_pc = 0, mispredict = 0, both counters = 0.
  - While reset is high: pred_rdy = 0, resolve_rdy = 0.
- Push:
  - pred_rdy = !full, with no same-cycle pass-through. On a full queue pred_rdy stays 0 even if a resolve fires that cycle.
  - Push fires on pred_val && pred_rdy. {pred_pc, pred_taken} is written at tail and tail advances modulo DEPTH.
- Resolve:
  - resolve_rdy = !empty.
  - Resolve fires on resolve_val && resolve_rdy; the entry at head is consumed and head advances modulo DEPTH.
  - resolve_val while empty is ignored: no update, no counter change.
- Outputs after a resolve (all registered, latency 1 cycle after the fire edge):
  - update_en = 1.
  - update_val = resolve_taken.
  - update_pc = the stored PC.
  - mispredict = (resolve_taken != stored pred_taken).
  - update_en and mispredict are single-cycle pulses. update_val and update_pc hold their last value when update_en = 0.
- Misprediction flush:
  - On a mispredicting resolve, every younger entry is squashed: count becomes 0 and head = tail.
  - A push firing in the same cycle is also discarded. It was accepted (pred_rdy = 1) but is wrong-path.
  - No update is ever produced for squashed entries.
- Simultaneous push and correct resolve:
  - Count is unchanged.
  - Both pointers advance.
- Counters:
  - num_branches increments on each resolve fire.
  - num_mispred increments on each mispredicting resolve.
  - Both saturate at all-ones and never wrap.
  - Counters update in the same edge as update_en is registered.
- Count and pointers:
  - Count is tracked explicitly, width clog2(DEPTH)+1, so full and empty are unambiguous.
  - Pointers wrap from DEPTH-1 to 0.

Decomposition:
- Shared package branch_pkg holds:
  - typedef br_entry_t: packed struct {logic [31:0] pc; logic pred;}
  - BR_PC_W = 32.
- Natural sub-module branch_pred_queue:
  - Circular buffer of br_entry_t with enq/deq/flush, full/empty and count.
  - Async-reset pointers.
  - Storage is not reset.
- The top level holds the compare logic, the output registers and the saturating counters.

Test Plan:
- Correct prediction: push PC=0x100 pred=1; resolve taken=1. Next cycle: update_en=1, update_val=1, update_pc=0x100, mispredict=0, num_branches=1, num_mispred=0.
- Fill and flush: push 4 entries (0x10, 0x20, 0x30, 0x40, all pred=0). Then pred_rdy=0. Resolve oldest taken=1 → mispredict=1, update_pc=0x10, num_mispred=1; queue empty (resolve_rdy=0); no further updates for 0x20–0x40.
- Simultaneous push and resolve:
  - Correct prediction with count=2 → count stays 2, and the in-order update PCs match push order across wrap-around (at least 6 pushes).
  - Mispredict with a same-cycle push → pushed entry is dropped and resolve_rdy=0.
- Empty resolve: resolve_val=1 with nothing in flight → no update_en, counters unchanged.
- Saturation: with CNT_W=4, issue 20 mispredicting resolves → num_branches=15 and num_mispred=15, held.
- Async reset mid-operation: assert reset between edges with 3 entries in flight and update_en high. Outputs clear immediately; after release, pred_rdy=1, resolve_rdy=0, counters=0.
